// File: rtl/fc_tile_sequencer.sv
// Tile sequencer for the accelerate_matrix FC datapath: streams x/bias words per tile, captures
// the four staggered output rows into a small result FIFO. Define FC_SEQ_PERF_EN for perf counters.
module fc_tile_sequencer #(
  parameter int unsigned NUM_TILES = 64,
  parameter int unsigned OUT_LAT   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [9:0]  xmem_addr,
  input  logic [31:0] xmem_rdata,
  output logic [7:0]  bmem_addr,
  input  logic [31:0] bmem_rdata,
  output logic [31:0] acc_w,
  output logic [31:0] acc_x,
  output logic [31:0] acc_bias,
  input  logic [15:0] acc_out1,
  input  logic [15:0] acc_out2,
  input  logic [15:0] acc_out3,
  input  logic [15:0] acc_out4,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [1:0]  res_row,
  output logic [7:0]  res_tile,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stall
);

  localparam int unsigned WaitW = (OUT_LAT > 2) ? $clog2(OUT_LAT - 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(OUT_LAT - 2);
  localparam logic [7:0] LastTile = 8'(NUM_TILES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPref,
    StFeed,
    StWait,
    StCapt,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  row;
    logic [7:0]  tile;
  } res_entry_t;

  state_e           state_q, state_d;
  logic [7:0]       tile_q, tile_d;
  logic [1:0]       idx_q, idx_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [9:0]       xaddr_q, xaddr_d;
  logic [7:0]       baddr_q, baddr_d;
  logic [31:0]      weight_q [4];
  logic [31:0]      acc_w_q, acc_x_q, acc_bias_q;
  res_entry_t       fifo_q [4];
  res_entry_t       push_entry;
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       cnt_q;
  logic             feed_en, push, pop, start_acc, drain_ok;

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign start_acc = (state_q == StIdle) && start;
  assign res_valid = (cnt_q != 3'd0);
  assign pop       = res_valid && res_ready;
  // FIFO will be empty after this cycle, counting a pop happening now.
  assign drain_ok  = (cnt_q == {2'b00, pop});

  assign xmem_addr = xaddr_q;
  assign bmem_addr = baddr_q;
  assign acc_w     = acc_w_q;
  assign acc_x     = acc_x_q;
  assign acc_bias  = acc_bias_q;

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    xaddr_d = xaddr_q;
    baddr_d = baddr_q;
    feed_en = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          state_d = StPref;
          tile_d  = '0;
          xaddr_d = '0;
          baddr_d = '0;
        end
      end
      StPref: begin
        state_d = StFeed;
        idx_d   = '0;
        xaddr_d = xaddr_q + 10'd1;
      end
      StFeed: begin
        feed_en = 1'b1;
        if (idx_q == 2'd3) begin
          state_d = StWait;
          wait_d  = '0;
        end else begin
          idx_d   = idx_q + 2'd1;
          xaddr_d = xaddr_q + 10'd1;
        end
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          state_d = StCapt;
          idx_d   = '0;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StCapt: begin
        push = 1'b1;
        if (idx_q == 2'd3) begin
          state_d = StDrain;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StDrain: begin
        if (drain_ok) begin
          if (tile_q == LastTile) begin
            state_d = StDone;
          end else begin
            state_d = StPref;
            tile_d  = tile_q + 8'd1;
            xaddr_d = {tile_q + 8'd1, 2'b00};
            baddr_d = tile_q + 8'd1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      tile_q  <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      xaddr_q <= '0;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      xaddr_q <= xaddr_d;
      baddr_q <= baddr_d;
    end
  end

  // Weights are frozen for the whole run so every tile sees the same matrix.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        weight_q[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      weight_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_w_q    <= '0;
      acc_x_q    <= '0;
      acc_bias_q <= '0;
    end else if (feed_en) begin
      acc_w_q <= weight_q[idx_q];
      acc_x_q <= xmem_rdata;
      if (idx_q == 2'd0) begin
        acc_bias_q <= bmem_rdata;
      end
    end
  end

  assign push_entry = '{data: {acc_out1, acc_out2, acc_out3, acc_out4}, row: idx_q, tile: tile_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_entry;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};
    end
  end

  assign res_data = fifo_q[rd_ptr_q].data;
  assign res_row  = fifo_q[rd_ptr_q].row;
  assign res_tile = fifo_q[rd_ptr_q].tile;

`ifdef FC_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (start_acc) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy && (perf_cycles_q != '1)) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (res_valid && !res_ready && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`else
  assign perf_cycles = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_fc_tile_sequencer.sv
// Directed bench for fc_tile_sequencer: two-tile runs against a fixed-latency accelerator model,
// with backpressure, write-while-busy, start-while-busy and mid-run reset sequences.
module tb_fc_tile_sequencer;

`ifdef FC_SEQ_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [9:0]  xmem_addr;
  logic [31:0] xmem_rdata;
  logic [7:0]  bmem_addr;
  logic [31:0] bmem_rdata;
  logic [31:0] acc_w, acc_x, acc_bias;
  logic [15:0] acc_out1, acc_out2, acc_out3, acc_out4;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [63:0] res_data;
  logic [1:0]  res_row;
  logic [7:0]  res_tile;
  logic [31:0] perf_cycles, perf_stall;

  fc_tile_sequencer #(
    .NUM_TILES(2),
    .OUT_LAT  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .xmem_addr  (xmem_addr),
    .xmem_rdata (xmem_rdata),
    .bmem_addr  (bmem_addr),
    .bmem_rdata (bmem_rdata),
    .acc_w      (acc_w),
    .acc_x      (acc_x),
    .acc_bias   (acc_bias),
    .acc_out1   (acc_out1),
    .acc_out2   (acc_out2),
    .acc_out3   (acc_out3),
    .acc_out4   (acc_out4),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_row    (res_row),
    .res_tile   (res_tile),
    .perf_cycles(perf_cycles),
    .perf_stall (perf_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xval(input int i);
    return 32'hA500_3C00 ^ (32'(i) * 32'h0103_0507);
  endfunction

  function automatic logic [31:0] bval(input int t);
    return 32'hB1A5_0000 + 32'(t) * 32'h0011_0013;
  endfunction

  // Layer memories with one-cycle read latency.
  always @(posedge clk) begin
    xmem_rdata <= xval(int'(xmem_addr));
    bmem_rdata <= bval(int'(bmem_addr));
  end

  // Accelerator model: row for operand set k appears 7 cycles after that set is on acc_*.
  logic [31:0] hw [7];
  logic [31:0] hx [7];
  logic [31:0] hb [7];
  always @(posedge clk) begin
    hw[0] <= acc_w;
    hx[0] <= acc_x;
    hb[0] <= acc_bias;
    for (int j = 1; j < 7; j++) begin
      hw[j] <= hw[j-1];
      hx[j] <= hx[j-1];
      hb[j] <= hb[j-1];
    end
  end
  assign acc_out1 = hx[6][15:0] + hw[6][15:0];
  assign acc_out2 = hx[6][31:16] ^ hw[6][31:16];
  assign acc_out3 = hb[6][15:0] + hw[6][15:0];
  assign acc_out4 = hb[6][31:16];

  logic [31:0] w_model [4];
  int checks = 0;
  int errors = 0;
  int cyc = -1;
  int done_cnt, done_cyc, pops, valid_seen;
  int sb_tile, sb_row;

  function automatic logic [63:0] exp_data(input int t, input int r);
    logic [31:0] x, w, b;
    x = xval(4 * t + r);
    w = w_model[r];
    b = bval(t);
    return {x[15:0] + w[15:0], x[31:16] ^ w[31:16], b[15:0] + w[15:0], b[31:16]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Advance to the middle of the next cycle, drive inputs, then score any pop this cycle.
  task automatic run_cycle(input logic rdy, input logic st, input logic we, input logic [1:0] wa,
                           input logic [31:0] wd);
    @(negedge clk);
    cyc++;
    res_ready = rdy;
    start     = st;
    cfg_we    = we;
    cfg_addr  = wa;
    cfg_wdata = wd;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (res_valid) valid_seen++;
    if (res_valid && res_ready) begin
      check("pop_tile", 64'(res_tile), 64'(sb_tile));
      check("pop_row", 64'(res_row), 64'(sb_row));
      check("pop_data", res_data, exp_data(sb_tile, sb_row));
      pops++;
      if (sb_row == 3) begin
        sb_row = 0;
        sb_tile++;
      end else begin
        sb_row++;
      end
    end
  endtask

  task automatic begin_run();
    done_cnt   = 0;
    done_cyc   = -1;
    pops       = 0;
    valid_seen = 0;
    sb_tile    = 0;
    sb_row     = 0;
    cyc        = -1;
    run_cycle(1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic load_weights();
    for (int r = 0; r < 4; r++) run_cycle(1'b1, 1'b0, 1'b1, 2'(r), w_model[r]);
    run_cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_xaddr"}, 64'(xmem_addr), 64'd0);
    check({tag, "_baddr"}, 64'(bmem_addr), 64'd0);
    check({tag, "_acc_w"}, 64'(acc_w), 64'd0);
    check({tag, "_acc_x"}, 64'(acc_x), 64'd0);
    check({tag, "_acc_bias"}, 64'(acc_bias), 64'd0);
    check({tag, "_res_data"}, res_data, 64'd0);
    check({tag, "_res_row"}, 64'(res_row), 64'd0);
    check({tag, "_res_tile"}, 64'(res_tile), 64'd0);
    check({tag, "_perf_cycles"}, 64'(perf_cycles), 64'd0);
    check({tag, "_perf_stall"}, 64'(perf_stall), 64'd0);
  endtask

  typedef struct {
    int         cyc;
    logic       st;
    logic       we;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_valid;
    logic [1:0] exp_row;
    logic [7:0] exp_tile;
    logic       chk_op;
    logic [1:0] k;
    logic       chk_addr;
    logic [9:0] exp_xa;
    logic [7:0] exp_ba;
  } vec_t;

  vec_t vecs [18];

  initial begin
    w_model[0] = 32'h0001_0203;
    w_model[1] = 32'h0405_0607;
    w_model[2] = 32'h0809_0A0B;
    w_model[3] = 32'h0C0D_0E0F;

    //          cyc st  we  busy done vld row tile op  k   addr xa     ba
    vecs[0]  = '{1,  0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 10'd0, 8'd0};
    vecs[1]  = '{2,  0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 10'd1, 8'd0};
    vecs[2]  = '{3,  0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 10'd0, 8'd0};
    vecs[3]  = '{7,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10'd0, 8'd0};
    vecs[4]  = '{10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10'd0, 8'd0};
    vecs[5]  = '{11, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 10'd0, 8'd0};
    vecs[6]  = '{12, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 10'd0, 8'd0};
    vecs[7]  = '{14, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0, 10'd0, 8'd0};
    vecs[8]  = '{15, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 10'd4, 8'd1};
    vecs[9]  = '{16, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 10'd5, 8'd1};
    vecs[10] = '{17, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 10'd0, 8'd0};
    vecs[11] = '{18, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 10'd0, 8'd0};
    vecs[12] = '{19, 0, 0, 1, 0, 0, 0, 1, 1, 2, 0, 10'd0, 8'd0};
    vecs[13] = '{20, 0, 0, 1, 0, 0, 0, 1, 1, 3, 0, 10'd0, 8'd0};
    vecs[14] = '{25, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 10'd0, 8'd0};
    vecs[15] = '{28, 0, 0, 1, 0, 1, 3, 1, 0, 0, 0, 10'd0, 8'd0};
    vecs[16] = '{29, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 10'd0, 8'd0};
    vecs[17] = '{30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'd0, 8'd0};

    // Power-on reset.
    #1 rst = 1'b0;
    #1 check_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    load_weights();

    // Baseline two-tile run with start-while-busy and weight write while busy.
    begin_run();
    for (int i = 0; i < 18; i++) begin
      while (cyc < vecs[i].cyc - 1) run_cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
      run_cycle(1'b1, vecs[i].st, vecs[i].we, 2'd2, 32'hFFFF_FFFF);
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
      check($sformatf("vec%0d_valid", i), 64'(res_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_row", i), 64'(res_row), 64'(vecs[i].exp_row));
        check($sformatf("vec%0d_tile", i), 64'(res_tile), 64'(vecs[i].exp_tile));
      end
      if (vecs[i].chk_op) begin
        check($sformatf("vec%0d_acc_x", i), 64'(acc_x),
              64'(xval(4 * int'(vecs[i].exp_tile) + int'(vecs[i].k))));
        check($sformatf("vec%0d_acc_w", i), 64'(acc_w), 64'(w_model[vecs[i].k]));
        check($sformatf("vec%0d_acc_bias", i), 64'(acc_bias), 64'(bval(int'(vecs[i].exp_tile))));
      end
      if (vecs[i].chk_addr) begin
        check($sformatf("vec%0d_xaddr", i), 64'(xmem_addr), 64'(vecs[i].exp_xa));
        check($sformatf("vec%0d_baddr", i), 64'(bmem_addr), 64'(vecs[i].exp_ba));
      end
    end
    repeat (4) run_cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    check("a_done_count", 64'(done_cnt), 64'd1);
    check("a_done_cycle", 64'(done_cyc), 64'd29);
    check("a_pops", 64'(pops), 64'd8);
    check("a_perf_cycles", 64'(perf_cycles), PerfEn ? 64'd28 : 64'd0);
    check("a_perf_stall", 64'(perf_stall), 64'd0);

    // Backpressure: ready low for the 10 cycles following tile 0 CAPT.
    begin_run();
    for (int c = 1; c <= 41; c++) begin
      run_cycle(!(c >= 14 && c <= 23), 1'b0, 1'b0, 2'd0, 32'd0);
      if (c == 20 || c == 24) begin
        check($sformatf("b%0d_valid", c), 64'(res_valid), 64'd1);
        check($sformatf("b%0d_row", c), 64'(res_row), 64'd3);
        check($sformatf("b%0d_tile", c), 64'(res_tile), 64'd0);
      end
      if (c == 25 || c == 34) check($sformatf("b%0d_valid", c), 64'(res_valid), 64'd0);
      if (c == 35) begin
        check("b35_valid", 64'(res_valid), 64'd1);
        check("b35_tile", 64'(res_tile), 64'd1);
      end
    end
    check("b_done_count", 64'(done_cnt), 64'd1);
    check("b_done_cycle", 64'(done_cyc), 64'd39);
    check("b_pops", 64'(pops), 64'd8);
    check("b_perf_cycles", 64'(perf_cycles), PerfEn ? 64'd38 : 64'd0);
    check("b_perf_stall", 64'(perf_stall), PerfEn ? 64'd10 : 64'd0);

    // Reset during tile 0 WAIT, then confirm quiet outputs and a clean rerun.
    begin_run();
    while (cyc < 6) run_cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    done_cnt   = 0;
    valid_seen = 0;
    repeat (12) run_cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    check("c_quiet_valid", 64'(valid_seen), 64'd0);
    check("c_quiet_done", 64'(done_cnt), 64'd0);
    check("c_quiet_busy", 64'(busy), 64'd0);
    load_weights();
    begin_run();
    while (cyc < 32) run_cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    check("c_done_count", 64'(done_cnt), 64'd1);
    check("c_done_cycle", 64'(done_cyc), 64'd29);
    check("c_pops", 64'(pops), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_tile_sequencer.md
# fc_tile_sequencer

Sequencer that drives the `accelerate_matrix` fully-connected datapath over a batch of input tiles. It holds the 4×4 int8 weight matrix, streams four x-words plus one bias word per tile from external read-only memories into the accelerator, and captures the four staggered 4×16-bit output rows. The captured rows are presented on a valid/ready result stream. It sits between the layer buffer memories and the accelerator.

## Interface
- `NUM_TILES`, 64: tiles per run (1..256).
- `OUT_LAT`, 5: cycles from the last feed cycle to the first output row of the accelerator (≥2).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, sampled in IDLE only.
- `busy`  out  1  high from the cycle after start is accepted until DONE.
- `done`  out  1  one-cycle pulse at end of run.
- `cfg_we`  in  1  weight-row write strobe.
- `cfg_addr`  in  2  weight row index.
- `cfg_wdata`  in  32  weight row, four int8 lanes.
- `xmem_addr`  out  10  x word address (4·tile+k).
- `xmem_rdata`  in  32  x word, one-cycle read latency.
- `bmem_addr`  out  8  bias address (tile).
- `bmem_rdata`  in  32  bias word, one-cycle read latency.
- `acc_w`, `acc_x`, `acc_bias`  out  32 each  accelerator operands, registered.
- `acc_out1`..`acc_out4`  in  16 each  accelerator results.
- `res_valid`  out  1; `res_ready`  in  1.
- `res_data`  out  64  {out1,out2,out3,out4}.
- `res_row`  out  2; `res_tile`  out  8.
- `perf_cycles`, `perf_stall`  out  32 each  (see Configuration).

## Operation
- Weight file: 4×32 registers written on `cfg_we`. Writes while `busy` are ignored. Reset value is 0.
- FSM states: IDLE → PREF → FEED(k=0..3) → WAIT(OUT_LAT−1 cycles) → CAPT(r=0..3) → DRAIN → PREF (next tile) or DONE → IDLE.
- PREF: present `xmem_addr`=4t, `bmem_addr`=t.
- FEED k:
  - `acc_w`=row k, `acc_x`=`xmem_rdata`.
  - `xmem_addr` advances to 4t+k+1.
  - `acc_bias` is loaded at k=0 and held until the next tile's k=0.
- CAPT r: push {acc_out1..4}, row r, tile t into a 4-entry result FIFO.
- Result stream:
  - `res_valid` = FIFO not empty. A pop occurs when `res_valid`&&`res_ready`.
  - Pops are allowed in any state. Ordering is strictly tile then row.
- DRAIN: wait until the FIFO is empty (including a pop in the current cycle). Then go to PREF with t+1, or to DONE if t=NUM_TILES−1.
- The FIFO cannot overflow: CAPT starts only with an empty FIFO.
- `start` asserted while busy is ignored. `start` held high in IDLE after DONE launches a new run.
- `res_ready` low stalls only DRAIN. The accelerator pipeline is never stalled.

## Timing
- Cycle n means n cycles after the edge that samples `start`=1 in IDLE.
- Tile 0 schedule:
  - PREF at 1, FEED at 2–5, WAIT at 6–9, CAPT at 10–13.
  - With `res_ready`=1, rows appear on the result stream at 11–14. DRAIN is at 14.
- Tile period with no backpressure is 14 cycles.
- DONE follows the last DRAIN. `done`=1 there for one cycle; `busy` drops in the same cycle.
- Reset values:
  - `busy`, `done`, `res_valid` = 0.
  - All address, operand, result, row, tile and perf outputs = 0.
  - FIFO is emptied; FSM returns to IDLE.
- Reset asserted mid-run aborts the run. No `done` is issued and no partial results are emitted after reset.
- Tile counter is 8 bits; `res_tile` reports the tile index without wrap for `NUM_TILES`≤256.

## Configuration
- `FC_SEQ_PERF_EN` defined:
  - `perf_cycles` counts cycles with `busy`=1.
  - `perf_stall` counts cycles with `res_valid`&&!`res_ready`.
  - Both clear when `start` is accepted and saturate at 2^32−1.
- Not defined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Load weight rows 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F. Run `NUM_TILES`=2 against a latency-5 accelerator model, with `res_ready`=1. Required:
  - Rows emitted at cycles 11–14 and 25–28, `res_tile`=0 then 1.
  - `done` at cycle 29.
- Check operand sequence during FEED of tile 1:
  - `acc_x` equals x words 4..7 in order.
  - `acc_w` steps through the four rows above.
  - `acc_bias`=bias[1] held for all four cycles.
- Hold `res_ready`=0 for 10 cycles after tile 0 CAPT. Required:
  - No data loss; tile 1 PREF is delayed 10 cycles.
  - `perf_stall`=10 with `FC_SEQ_PERF_EN`; `perf_stall`=0 without it.
- Pulse `cfg_we` with 0xFFFFFFFF to row 2 while `busy`. Then compare results against the original weights: expected result unchanged, weight row 2 read back unchanged.
- Assert `rst`=0 during tile 0 WAIT. Required: all outputs 0 immediately, `res_valid` never asserts, and a new `start` runs cleanly from tile 0.
- Assert `start` while busy at cycle 7: ignored, single `done` at cycle 29.
